// File: rtl/bus_arbiter.sv
// bus_arbiter
//
// Shares the single system bus between the 6510 CPU, the video chip and an
// external DMA master (cartridge / REU port). Drives the CPU's RDY and AEC
// inputs. On any request RDY drops first, the arbiter waits BA_DELAY cycles
// so the CPU can finish any pending write cycles, and then AEC is removed and
// the bus is granted. One clk tick equals one bus (phi2) cycle.
//
// Parameters:
//   BA_DELAY       cycles RDY is low with AEC still high before a grant (1..15)
//   DMA_MAX_BURST  max consecutive DMA grant cycles before a forced one-cycle
//                  CPU yield; 0 = unlimited (0..255)
//
// Ports:
//   clk        in   bus-cycle clock; all state changes on the rising edge
//   reset      in   asynchronous, active-high reset
//   vic_req    in   video chip requests the bus (level, held while needed)
//   dma_req    in   external DMA requests the bus (level, held while needed)
//   rdy        out  to CPU RDY; 0 = CPU must halt on its next read cycle
//   aec        out  to CPU AEC; 1 = CPU owns the address/data bus
//   vic_grant  out  video chip owns the bus this cycle
//   dma_grant  out  DMA master owns the bus this cycle
//
// All outputs are registered and decoded from the next state, so they always
// match the state register and at most one of {aec, vic_grant, dma_grant} is
// ever high.

module bus_arbiter #(
    parameter int unsigned BA_DELAY      = 3,
    parameter int unsigned DMA_MAX_BURST = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic vic_req,
    input  logic dma_req,
    output logic rdy,
    output logic aec,
    output logic vic_grant,
    output logic dma_grant
);

    localparam logic [3:0] BaDelay  = 4'(BA_DELAY);
    localparam logic [7:0] MaxBurst = 8'(DMA_MAX_BURST);
    localparam bit         BurstLim = (DMA_MAX_BURST != 0);

    typedef enum logic [2:0] {
        StCpu   = 3'd0,
        StWarn  = 3'd1,
        StVic   = 3'd2,
        StDma   = 3'd3,
        StYield = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [7:0] bcnt_q, bcnt_d;

    logic rdy_d;
    logic aec_d;
    logic vic_grant_d;
    logic dma_grant_d;

    logic any_req;
    assign any_req = vic_req | dma_req;

    // Next-state logic. Video always wins over DMA; DMA never preempts video.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;

        unique case (state_q)
            StCpu: begin
                if (any_req) begin
                    state_d = StWarn;
                    wcnt_d  = 4'd1;
                end
            end

            StWarn: begin
                // The warning phase always runs to completion, even if the
                // request is withdrawn part way through.
                if (wcnt_q < BaDelay) begin
                    wcnt_d = wcnt_q + 4'd1;
                end else if (vic_req) begin
                    state_d = StVic;
                end else if (dma_req) begin
                    state_d = StDma;
                end else begin
                    state_d = StCpu;
                    bcnt_d  = 8'd0;
                end
            end

            StVic: begin
                if (vic_req) begin
                    state_d = StVic;
                end else if (dma_req) begin
                    // CPU is already off the bus, so hand over directly.
                    state_d = StDma;
                end else begin
                    state_d = StCpu;
                    bcnt_d  = 8'd0;
                end
            end

            StDma: begin
                if (vic_req) begin
                    // DMA is paused; its burst count survives the pause.
                    state_d = StVic;
                end else if (!dma_req) begin
                    state_d = StCpu;
                    bcnt_d  = 8'd0;
                end else if (BurstLim && ((bcnt_q + 8'd1) == MaxBurst)) begin
                    state_d = StYield;
                    bcnt_d  = 8'd0;
                end else if (BurstLim) begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end

            StYield: begin
                bcnt_d = 8'd0;
                if (any_req) begin
                    state_d = StWarn;
                    wcnt_d  = 4'd1;
                end else begin
                    state_d = StCpu;
                end
            end

            default: begin
                state_d = StCpu;
                wcnt_d  = 4'd0;
                bcnt_d  = 8'd0;
            end
        endcase
    end

    // Output decode of the next state; registered below so outputs change on
    // the same edge as the state.
    always_comb begin
        rdy_d       = 1'b1;
        aec_d       = 1'b1;
        vic_grant_d = 1'b0;
        dma_grant_d = 1'b0;

        unique case (state_d)
            StCpu, StYield: begin
                rdy_d = 1'b1;
                aec_d = 1'b1;
            end
            StWarn: begin
                rdy_d = 1'b0;
                aec_d = 1'b1;
            end
            StVic: begin
                rdy_d       = 1'b0;
                aec_d       = 1'b0;
                vic_grant_d = 1'b1;
            end
            StDma: begin
                rdy_d       = 1'b0;
                aec_d       = 1'b0;
                dma_grant_d = 1'b1;
            end
            default: begin
                rdy_d = 1'b1;
                aec_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StCpu;
            wcnt_q    <= 4'd0;
            bcnt_q    <= 8'd0;
            rdy       <= 1'b1;
            aec       <= 1'b1;
            vic_grant <= 1'b0;
            dma_grant <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            rdy       <= rdy_d;
            aec       <= aec_d;
            vic_grant <= vic_grant_d;
            dma_grant <= dma_grant_d;
        end
    end

endmodule
